pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multi-cycle PC/IR sequencing FSM with optional exception support.
// Define PC_SEQ_EXC_EN to enable the invalid-opcode/overflow exception path (EXC_SAVE/EXC_VEC).
module pc_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       Overflow,
   input  logic       MemReady,
   output logic [1:0] PCSource,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       EPCWrite,
   output logic       VecSel,
   output logic       ExcCause
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_COP0  = 6'b010000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_RFE   = 6'b010000;

   typedef enum logic [2:0] {
      FETCH    = 3'd0,
      DECODE   = 3'd1,
      EXEC     = 3'd2,
      BRANCH   = 3'd3,
      JUMP     = 3'd4,
      RFE      = 3'd5,
      EXC_SAVE = 3'd6,
      EXC_VEC  = 3'd7
   } state_t;

   state_t     state, state_nx;
   logic [5:0] op_q;
   logic       cause_q, cause_nx;
   logic [1:0] src;
   logic       pcw, irw, epcw, vsel, bad_op;

`ifndef PC_SEQ_EXC_EN
   logic unused_ovf;
   assign unused_ovf = Overflow;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         op_q    <= '0;
         cause_q <= 1'b0;
      end else begin
         state   <= state_nx;
         cause_q <= cause_nx;
         if (state == DECODE) op_q <= Opcode;
      end
   end

   always_comb begin
      state_nx = state;
      cause_nx = cause_q;
      src      = 2'b00;
      pcw      = 1'b0;
      irw      = 1'b0;
      epcw     = 1'b0;
      vsel     = 1'b0;
      bad_op   = 1'b0;
      case (state)
         FETCH: begin
            if (MemReady) begin
               pcw      = 1'b1;
               irw      = 1'b1;
               state_nx = DECODE;
            end
         end
         DECODE: begin
            case (Opcode)
               OP_J, OP_JAL:                    state_nx = JUMP;
               OP_BEQ, OP_BNE:                  state_nx = BRANCH;
               OP_RTYPE, OP_ADDI, OP_LW, OP_SW: state_nx = EXEC;
               OP_COP0: begin
                  if (Funct == FN_RFE) state_nx = RFE;
                  else                 bad_op   = 1'b1;
               end
               default:                         bad_op   = 1'b1;
            endcase
            if (bad_op) begin
`ifdef PC_SEQ_EXC_EN
               state_nx = EXC_SAVE;
               cause_nx = 1'b0;
`else
               state_nx = FETCH;
`endif
            end
         end
         EXEC: begin
            state_nx = FETCH;
`ifdef PC_SEQ_EXC_EN
            // overflow traps only for signed arithmetic, judged on the latched opcode
            if (Overflow && (op_q == OP_RTYPE || op_q == OP_ADDI)) begin
               state_nx = EXC_SAVE;
               cause_nx = 1'b1;
            end
`endif
         end
         BRANCH: begin
            src      = 2'b01;
            pcw      = (op_q == OP_BNE) ? ~Zero : Zero;
            state_nx = FETCH;
         end
         JUMP: begin
            src      = 2'b10;
            pcw      = 1'b1;
            state_nx = FETCH;
         end
         RFE: begin
            src      = 2'b11;
            pcw      = 1'b1;
            state_nx = FETCH;
         end
`ifdef PC_SEQ_EXC_EN
         EXC_SAVE: begin
            epcw     = 1'b1;
            state_nx = EXC_VEC;
         end
         EXC_VEC: begin
            src      = 2'b10;
            vsel     = 1'b1;
            pcw      = 1'b1;
            state_nx = FETCH;
         end
`endif
         default: state_nx = FETCH;
      endcase
   end

   // reset masks every output combinationally, not just from the next edge
   assign PCSource = reset ? 2'b00 : src;
   assign PCWrite  = reset ? 1'b0  : pcw;
   assign IRWrite  = reset ? 1'b0  : irw;
   assign EPCWrite = reset ? 1'b0  : epcw;
   assign VecSel   = reset ? 1'b0  : vsel;
   assign ExcCause = reset ? 1'b0  : cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset corners,
// and random instruction streams checked against an instruction-level model.
module tb_pc_sequencer;

`ifdef PC_SEQ_EXC_EN
   localparam bit EXC = 1'b1;
`else
   localparam bit EXC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, Zero, Overflow, MemReady;
   logic [5:0] Opcode, Funct;
   logic [1:0] PCSource;
   logic       PCWrite, IRWrite, EPCWrite, VecSel, ExcCause;

   int errs   = 0;
   int checks = 0;
   logic cause;  // model of the held exception cause

   typedef struct {
      logic       rst, mr, z, ov;
      logic [5:0] op, fn;
      logic [6:0] exp;
      string      tag;
   } vec_t;
   vec_t tbl[$];

   pc_sequencer dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .Overflow(Overflow), .MemReady(MemReady), .PCSource(PCSource), .PCWrite(PCWrite),
      .IRWrite(IRWrite), .EPCWrite(EPCWrite), .VecSel(VecSel), .ExcCause(ExcCause)
   );

   always #5 clk = ~clk;

   // {PCSource, PCWrite, IRWrite, EPCWrite, VecSel, ExcCause}
   function automatic logic [6:0] e(input logic [1:0] s, input logic pw, iw, ew, vs, c);
      return {s, pw, iw, ew, vs, c};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom_range(0, 63));
   endfunction

   task automatic cyc(input logic rst, mr, z, ov, input logic [5:0] op, fn,
                      input logic [6:0] exp, input string tag);
      logic [6:0] act;
      reset = rst; MemReady = mr; Zero = z; Overflow = ov; Opcode = op; Funct = fn;
      @(negedge clk);
      act = {PCSource, PCWrite, IRWrite, EPCWrite, VecSel, ExcCause};
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b want %b (src,pcw,irw,epcw,vsel,cause)", tag, act, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic rst, mr, z, ov, input logic [5:0] op, fn,
                      input logic [6:0] exp, input string tag);
      vec_t v;
      v.rst = rst; v.mr = mr; v.z = z; v.ov = ov; v.op = op; v.fn = fn; v.exp = exp; v.tag = tag;
      tbl.push_back(v);
   endtask

   // instruction class from the opcode map: 0 jump, 1 branch, 2 exec, 3 rfe, 4 invalid
   function automatic int kind(input logic [5:0] op, fn);
      if (op == 6'h02 || op == 6'h03) return 0;
      if (op == 6'h04 || op == 6'h05) return 1;
      if (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2b) return 2;
      if (op == 6'h10 && fn == 6'h10) return 3;
      return 4;
   endfunction

   task automatic exc_seq();
      cyc(0, rb(), rb(), rb(), r6(), r6(), e(2'b00, 0, 0, 1, 0, cause), "exc_save");
      cyc(0, rb(), rb(), rb(), r6(), r6(), e(2'b10, 1, 0, 0, 1, cause), "exc_vec");
   endtask

   // one whole instruction: stalled fetch, decode, then its class's tail
   task automatic run_instr(input logic [5:0] op, fn, input int stalls, input logic z, ov);
      for (int i = 0; i < stalls; i++)
         cyc(0, 0, rb(), rb(), r6(), r6(), e(2'b00, 0, 0, 0, 0, cause), "rnd_stall");
      cyc(0, 1, rb(), rb(), r6(), r6(), e(2'b00, 1, 1, 0, 0, cause), "rnd_fetch");
      cyc(0, rb(), rb(), rb(), op, fn, e(2'b00, 0, 0, 0, 0, cause), "rnd_decode");
      case (kind(op, fn))
         0: cyc(0, rb(), rb(), rb(), r6(), r6(), e(2'b10, 1, 0, 0, 0, cause), "rnd_jump");
         1: cyc(0, rb(), z, rb(), r6(), r6(),
                e(2'b01, (op == 6'h05) ? !z : z, 0, 0, 0, cause), "rnd_branch");
         2: begin
            cyc(0, rb(), rb(), ov, r6(), r6(), e(2'b00, 0, 0, 0, 0, cause), "rnd_exec");
            if (EXC && ov && (op == 6'h00 || op == 6'h08)) begin
               cause = 1'b1;
               exc_seq();
            end
         end
         3: cyc(0, rb(), rb(), rb(), r6(), r6(), e(2'b11, 1, 0, 0, 0, cause), "rnd_rfe");
         default: if (EXC) begin
            cause = 1'b0;
            exc_seq();
         end
      endcase
   endtask

   initial begin
      logic c1;
      logic [5:0] ops [9];
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b, 6'h10};
      c1 = EXC;

      // directed table, starting in FETCH right after reset
      add(0, 1, 0, 1, 6'h3f, 6'h3f, e(0, 1, 1, 0, 0, 0), "beq_t_fetch");
      add(0, 0, 1, 1, 6'h04, 6'h00, e(0, 0, 0, 0, 0, 0), "beq_t_decode");
      add(0, 0, 1, 0, 6'h3f, 6'h00, e(1, 1, 0, 0, 0, 0), "beq_taken");
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "beq_n_fetch");
      add(0, 0, 1, 0, 6'h04, 6'h00, e(0, 0, 0, 0, 0, 0), "beq_n_decode");
      add(0, 0, 0, 1, 6'h05, 6'h00, e(1, 0, 0, 0, 0, 0), "beq_not_taken");
      add(0, 1, 1, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "bne_z1_fetch");
      add(0, 0, 0, 0, 6'h05, 6'h00, e(0, 0, 0, 0, 0, 0), "bne_z1_decode");
      add(0, 0, 1, 0, 6'h04, 6'h00, e(1, 0, 0, 0, 0, 0), "bne_z1_branch");
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "bne_z0_fetch");
      add(0, 0, 1, 0, 6'h05, 6'h00, e(0, 0, 0, 0, 0, 0), "bne_z0_decode");
      add(0, 0, 0, 0, 6'h04, 6'h00, e(1, 1, 0, 0, 0, 0), "bne_z0_branch");
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "j_fetch");
      add(0, 0, 0, 0, 6'h02, 6'h00, e(0, 0, 0, 0, 0, 0), "j_decode");
      add(0, 1, 1, 1, 6'h3f, 6'h00, e(2, 1, 0, 0, 0, 0), "j_jump");
      add(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "j_back_fetch");
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "jal_fetch");
      add(0, 0, 0, 0, 6'h03, 6'h00, e(0, 0, 0, 0, 0, 0), "jal_decode");
      add(0, 0, 0, 0, 6'h00, 6'h00, e(2, 1, 0, 0, 0, 0), "jal_jump");
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "addi_fetch");
      add(0, 0, 0, 0, 6'h08, 6'h00, e(0, 0, 0, 0, 0, 0), "addi_decode");
      add(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "addi_exec");
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "lw_fetch");
      add(0, 0, 0, 0, 6'h23, 6'h00, e(0, 0, 0, 0, 0, 0), "lw_decode");
      add(0, 0, 0, 1, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "lw_exec_ovf");
      add(0, 0, 1, 1, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "stall_a");
      add(0, 0, 1, 1, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "stall_b");
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "ovf_fetch");
      add(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "ovf_decode");
      add(0, 0, 0, 1, 6'h23, 6'h00, e(0, 0, 0, 0, 0, 0), "ovf_exec");
      if (EXC) begin
         add(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 1, 0, 1), "ovf_exc_save");
         add(0, 0, 0, 0, 6'h00, 6'h00, e(2, 1, 0, 0, 1, 1), "ovf_exc_vec");
      end
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, c1), "inv_fetch");
      add(0, 0, 0, 0, 6'h3f, 6'h00, e(0, 0, 0, 0, 0, c1), "inv_decode");
      if (EXC) begin
         add(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 1, 0, 0), "inv_exc_save");
         add(0, 0, 0, 0, 6'h00, 6'h00, e(2, 1, 0, 0, 1, 0), "inv_exc_vec");
      end
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "rfe_fetch");
      add(0, 0, 0, 0, 6'h10, 6'h10, e(0, 0, 0, 0, 0, 0), "rfe_decode");
      add(0, 0, 0, 0, 6'h00, 6'h00, e(3, 1, 0, 0, 0, 0), "rfe_exec");
      add(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "cop0_fetch");
      add(0, 0, 0, 0, 6'h10, 6'h11, e(0, 0, 0, 0, 0, 0), "cop0_bad_decode");
      if (EXC) begin
         add(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 1, 0, 0), "cop0_exc_save");
         add(0, 0, 0, 0, 6'h00, 6'h00, e(2, 1, 0, 0, 1, 0), "cop0_exc_vec");
      end
      add(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "final_fetch");

      cyc(1, 1, 1, 1, 6'h02, 6'h00, e(0, 0, 0, 0, 0, 0), "reset_a");
      cyc(1, 1, 1, 1, 6'h02, 6'h00, e(0, 0, 0, 0, 0, 0), "reset_b");
      foreach (tbl[i])
         cyc(tbl[i].rst, tbl[i].mr, tbl[i].z, tbl[i].ov, tbl[i].op, tbl[i].fn, tbl[i].exp, tbl[i].tag);

      // reset held two cycles in JUMP, then a three-cycle memory stall
      cyc(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "rj_fetch");
      cyc(0, 0, 0, 0, 6'h02, 6'h00, e(0, 0, 0, 0, 0, 0), "rj_decode");
      cyc(1, 1, 1, 1, 6'h02, 6'h00, e(0, 0, 0, 0, 0, 0), "rj_reset_jump");
      cyc(1, 1, 1, 1, 6'h02, 6'h00, e(0, 0, 0, 0, 0, 0), "rj_reset_hold");
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 1, 1, 6'h02, 6'h00, e(0, 0, 0, 0, 0, 0), "rj_stall");
      cyc(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "rj_fetch_go");
      cyc(0, 0, 0, 0, 6'h2b, 6'h00, e(0, 0, 0, 0, 0, 0), "rj_sw_decode");
      cyc(0, 0, 0, 1, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "rj_sw_exec");

      // reset landing on the exception vector cycle must clear the cause
      cyc(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "rx_fetch");
      cyc(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "rx_decode");
      cyc(0, 0, 0, 1, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "rx_exec");
      cyc(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, EXC, 0, EXC), "rx_save_or_fetch");
      cyc(1, 1, 1, 1, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "rx_reset");
      cyc(0, 1, 0, 0, 6'h00, 6'h00, e(0, 1, 1, 0, 0, 0), "rx_fetch_clear");
      cyc(0, 0, 0, 0, 6'h2b, 6'h00, e(0, 0, 0, 0, 0, 0), "rx_sw_decode");
      cyc(0, 0, 0, 0, 6'h00, 6'h00, e(0, 0, 0, 0, 0, 0), "rx_sw_exec");

      cause = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op, fn;
         int pick;
         pick = $urandom_range(0, 10);
         op = (pick < 9) ? ops[pick] : r6();
         fn = (op == 6'h10 && rb()) ? 6'h10 : r6();
         run_instr(op, fn, $urandom_range(0, 3), rb(), rb());
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
